// File: rtl/croma_pkg.sv
// croma_pkg: shared types and constants for the chroma sequencer.
//   modo_t   - edit mode (colour index editing vs. tone editing)
//   commit_t - frame-synchronous commit state
//   *_RST    - power-on / reset values of the committed and shadow registers
//   ton_step - saturating tone increment/decrement helper
package croma_pkg;

  typedef enum logic {
    MODO_COLOR = 1'b0,
    MODO_TONO  = 1'b1
  } modo_t;

  typedef enum logic [1:0] {
    CM_IDLE  = 2'd0,
    CM_PEND  = 2'd1,
    CM_APPLY = 2'd2
  } commit_t;

  localparam logic [2:0] COLORL_RST = 3'd7;
  localparam logic [2:0] COLORP_RST = 3'd0;
  localparam logic [7:0] TON_RST    = 8'd255;

  // Saturating step: clamps at 0 and 255 instead of wrapping.
  function automatic logic [7:0] ton_step(input logic [7:0] t, input logic up,
                                          input logic [7:0] step);
    if (up) return (t > (8'd255 - step)) ? 8'd255 : t + step;
    else    return (t < step) ? 8'd0 : t - step;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// antirrebote: button conditioner.
//   Clk    in  system clock
//   reset  in  synchronous, active-high reset
//   raw    in  asynchronous raw button level
//   pulse  out one-cycle event on each accepted press, plus auto-repeat
//              pulses every REP_CYCLES while held when REP_EN is set
// Raw edge to first pulse is 2 + DEB_CYCLES cycles.
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned REP_CYCLES = 12500000,
  parameter bit          REP_EN     = 1'b0
) (
  input  logic Clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RW = $clog2(REP_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] REP_LOAD = RW'(REP_CYCLES - 1);

  logic          s1, s2, acc;
  logic [DW-1:0] deb;
  logic [RW-1:0] rep;

  always_ff @(posedge Clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      acc   <= 1'b0;
      deb   <= DEB_LOAD;
      rep   <= REP_LOAD;
      pulse <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      pulse <= 1'b0;
      // Down-counter restarts whenever the synchronised level agrees with
      // the accepted one, so only an unbroken run of DEB_CYCLES is accepted.
      if (s2 == acc) begin
        deb <= DEB_LOAD;
      end else if (deb == '0) begin
        acc <= s2;
        deb <= DEB_LOAD;
        if (s2) begin
          pulse <= 1'b1;
          rep   <= REP_LOAD;
        end
      end else begin
        deb <= deb - 1'b1;
      end
      // acc is already high here, so this never coincides with the
      // rising-acceptance branch above.
      if (REP_EN && acc) begin
        if (rep == '0) begin
          pulse <= 1'b1;
          rep   <= REP_LOAD;
        end else begin
          rep <= rep - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/secuenciador_croma.sv
// secuenciador_croma: button-driven colour/tone editor with frame-synchronous
// commit.
//   Clk, reset               clock and synchronous active-high reset
//   Up, Down, Tono, color, Lp raw buttons
//   Vsinc                    active-low vertical sync (Clk-synchronous)
//   ColorL, ColorP, ton      committed letter colour, background colour, tone
//   sel_obj                  edit target (0 letter, 1 background)
//   modo                     edit mode (0 COLOR, 1 TONO)
//   pendiente                shadow edits waiting for the next frame edge
//
// state      | meaning
// MODO_COLOR | Up/Down step the selected colour index, modulo 8
// MODO_TONO  | Up/Down step the tone by TON_STEP, saturating
// CM_IDLE    | outputs match shadows
// CM_PEND    | shadows changed; waiting for a Vsinc falling edge
// CM_APPLY   | shadows copied to outputs at the end of this cycle
module secuenciador_croma
  import croma_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned REP_CYCLES = 12500000,
  parameter int unsigned TON_STEP   = 8
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       Tono,
  input  logic       color,
  input  logic       Lp,
  input  logic       Vsinc,
  output logic [2:0] ColorL,
  output logic [2:0] ColorP,
  output logic [7:0] ton,
  output logic       sel_obj,
  output logic       modo,
  output logic       pendiente
);

  localparam logic [7:0] STEP = 8'(TON_STEP);

  logic [4:0] raw, pulse;
  assign raw = {Lp, color, Tono, Down, Up};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    antirrebote #(
      .DEB_CYCLES(DEB_CYCLES),
      .REP_CYCLES(REP_CYCLES),
      .REP_EN    (i < 2)
    ) u_ar (
      .Clk  (Clk),
      .reset(reset),
      .raw  (raw[i]),
      .pulse(pulse[i])
    );
  end

  modo_t      modo_q, modo_d;
  logic       sel_q, sel_d;
  logic [2:0] sh_l, sh_l_d, sh_p, sh_p_d;
  logic [7:0] sh_t, sh_t_d;
  logic       chg, up_ev, dn_ev;
  commit_t    cm_q, cm_d;
  logic       vs_q, vs_fall;

  assign vs_fall = vs_q & ~Vsinc;

  always_ff @(posedge Clk) begin
    if (reset) begin
      modo_q <= MODO_COLOR;
      sel_q  <= 1'b0;
      sh_l   <= COLORL_RST;
      sh_p   <= COLORP_RST;
      sh_t   <= TON_RST;
      cm_q   <= CM_IDLE;
      vs_q   <= 1'b1;
      ColorL <= COLORL_RST;
      ColorP <= COLORP_RST;
      ton    <= TON_RST;
    end else begin
      modo_q <= modo_d;
      sel_q  <= sel_d;
      sh_l   <= sh_l_d;
      sh_p   <= sh_p_d;
      sh_t   <= sh_t_d;
      cm_q   <= cm_d;
      vs_q   <= Vsinc;
      // Copies the shadows as they stood during APPLY; a write landing in
      // the same cycle is picked up by the next frame.
      if (cm_q == CM_APPLY) begin
        ColorL <= sh_l;
        ColorP <= sh_p;
        ton    <= sh_t;
      end
    end
  end

  // Mode and target resolve first so a coincident Up/Down uses them.
  always_comb begin
    modo_d = modo_q;
    sel_d  = sel_q ^ pulse[4];
    sh_l_d = sh_l;
    sh_p_d = sh_p;
    sh_t_d = sh_t;
    up_ev  = pulse[0] & ~pulse[1];
    dn_ev  = pulse[1] & ~pulse[0];
    if (pulse[2])      modo_d = MODO_TONO;
    else if (pulse[3]) modo_d = MODO_COLOR;
    if (up_ev || dn_ev) begin
      if (modo_d == MODO_TONO) sh_t_d = ton_step(sh_t, up_ev, STEP);
      else if (sel_d)          sh_p_d = up_ev ? sh_p + 3'd1 : sh_p - 3'd1;
      else                     sh_l_d = up_ev ? sh_l + 3'd1 : sh_l - 3'd1;
    end
    chg = (sh_l_d != sh_l) || (sh_p_d != sh_p) || (sh_t_d != sh_t);
  end

  always_comb begin
    cm_d = cm_q;
    case (cm_q)
      CM_IDLE:  if (chg) cm_d = CM_PEND;
      CM_PEND:  if (vs_fall) cm_d = CM_APPLY;
      CM_APPLY: cm_d = chg ? CM_PEND : CM_IDLE;
      default:  cm_d = CM_IDLE;
    endcase
  end

  assign sel_obj   = sel_q;
  assign modo      = modo_q;
  assign pendiente = (cm_q != CM_IDLE);

endmodule
